// File: rtl/pf_reset_pkg.sv
// Shared types and sizing helpers for the sequenced fabric reset block.
package pf_reset_pkg;

    typedef enum logic [1:0] {
        S_PWRUP  = 2'd0,
        S_ASSERT = 2'd1,
        S_STAGE  = 2'd2,
        S_DONE   = 2'd3
    } seq_state_t;

    // Wide enough to hold the largest delay, so every terminal value is representable.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pf_reset_dly_cnt.sv
// Delay up-counter with clear and terminal detect against a limit chosen at runtime.
module pf_reset_dly_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             INTERNAL_RST,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge INTERNAL_RST) begin
        if (!INTERNAL_RST) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Terminal one count early so the event lands exactly on the limit-th edge.
    assign o_term = (r_cnt == (i_limit - 1'b1));

endmodule

// File: rtl/pf_reset_seq_multi.sv
// Releases NUM_CH fabric reset domains in order after INTERNAL_RST or a software re-reset.
module pf_reset_seq_multi
    import pf_reset_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int POWERUP_DLY = 16,
    parameter int STAGE_DLY   = 8,
    parameter int MIN_ASSERT  = 4
) (
    input  logic              CLK,
    input  logic              INTERNAL_RST,
    input  logic              SW_RST_REQ,
    input  logic              FF_US_RESTORE,
    output logic [NUM_CH-1:0] FABRIC_RESET_N,
    output logic              SEQ_DONE
);

    localparam int CNT_W = cnt_width(POWERUP_DLY, STAGE_DLY, MIN_ASSERT);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    seq_state_t        r_state;
    logic [NUM_CH-1:0] r_ch;
    logic [IDX_W-1:0]  r_idx;
    logic              r_done;

    logic [CNT_W-1:0]  w_limit;
    logic              w_term;
    logic              w_clr;
    logic              w_en;

    always_comb begin
        w_limit = CNT_W'(STAGE_DLY);
        case (r_state)
            S_PWRUP:  w_limit = CNT_W'(POWERUP_DLY);
            S_ASSERT: w_limit = CNT_W'(MIN_ASSERT);
            default:  w_limit = CNT_W'(STAGE_DLY);
        endcase
    end

    // Every release reloads the counter; a request restarts it from zero.
    assign w_clr = SW_RST_REQ | w_term;
    assign w_en  = (r_state != S_DONE);

    pf_reset_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .CLK          (CLK),
        .INTERNAL_RST (INTERNAL_RST),
        .i_clr        (w_clr),
        .i_en         (w_en),
        .i_limit      (w_limit),
        .o_term       (w_term)
    );

    always_ff @(posedge CLK or negedge INTERNAL_RST) begin
        if (!INTERNAL_RST) begin
            r_state <= S_PWRUP;
            r_ch    <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else if (SW_RST_REQ) begin
            r_state <= S_ASSERT;
            r_ch    <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_PWRUP, S_ASSERT: begin
                    if (w_term) begin
                        r_ch[0] <= 1'b1;
                        if (NUM_CH == 1) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_STAGE;
                            r_idx   <= IDX_W'(1);
                        end
                    end
                end
                S_STAGE: begin
                    if (w_term) begin
                        r_ch[r_idx] <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_PWRUP;
                end
            endcase
        end
    end

    // Restore bypass is purely combinational so it acts in the same cycle.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
        assign FABRIC_RESET_N[gi] = r_ch[gi] | FF_US_RESTORE;
    end

    assign SEQ_DONE = r_done;

endmodule

// File: tb/tb_pf_reset_seq_multi.sv
// Scoreboard bench: three parameterisations driven in parallel, checked against release-edge formulas.
module tb_pf_reset_seq_multi;

    logic CLK = 1'b0;
    logic INTERNAL_RST = 1'b1;
    logic SW_RST_REQ = 1'b0;
    logic FF_US_RESTORE = 1'b0;

    logic [3:0] fab_a;
    logic       done_a;
    logic [0:0] fab_b;
    logic       done_b;
    logic [7:0] fab_c;
    logic       done_c;

    always #5 CLK = ~CLK;

    pf_reset_seq_multi u_a (
        .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .SW_RST_REQ(SW_RST_REQ),
        .FF_US_RESTORE(FF_US_RESTORE), .FABRIC_RESET_N(fab_a), .SEQ_DONE(done_a));

    pf_reset_seq_multi #(.NUM_CH(1), .POWERUP_DLY(16), .STAGE_DLY(1), .MIN_ASSERT(1)) u_b (
        .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .SW_RST_REQ(SW_RST_REQ),
        .FF_US_RESTORE(FF_US_RESTORE), .FABRIC_RESET_N(fab_b), .SEQ_DONE(done_b));

    pf_reset_seq_multi #(.NUM_CH(8), .POWERUP_DLY(3), .STAGE_DLY(2), .MIN_ASSERT(5)) u_c (
        .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .SW_RST_REQ(SW_RST_REQ),
        .FF_US_RESTORE(FF_US_RESTORE), .FABRIC_RESET_N(fab_c), .SEQ_DONE(done_c));

    typedef struct packed {
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] c;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: time origin of the current release sequence.
    int cyc     = 0;
    bit active  = 0;
    int t0      = 0;
    bit use_min = 0;

    // Channel k is released once the edge count reaches origin + first delay + k*stage.
    function automatic logic [8:0] exp_out(input int nch, input int pd, input int sd, input int ma);
        logic [7:0] ch;
        logic [7:0] mask;
        int d0;
        ch   = '0;
        mask = 8'((1 << nch) - 1);
        d0   = use_min ? ma : pd;
        for (int k = 0; k < nch; k++) begin
            if (active && (cyc >= t0 + d0 + k * sd)) ch[k] = 1'b1;
        end
        return {ch[nch-1], ch | (FF_US_RESTORE ? mask : 8'h00)};
    endfunction

    function automatic sb_entry_t exp_all();
        sb_entry_t e;
        e.a = exp_out(4, 16, 8, 4);
        e.b = exp_out(1, 16, 1, 1);
        e.c = exp_out(8, 3, 2, 5);
        return e;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got done=%b fab=%b, expected done=%b fab=%b",
                     name, cyc, act[8], act[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic check_all(input string tag, input sb_entry_t e);
        chk({tag, "_a"}, {done_a, 4'b0, fab_a}, e.a);
        chk({tag, "_b"}, {done_b, 7'b0, fab_b}, e.b);
        chk({tag, "_c"}, {done_c, fab_c}, e.c);
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() != 0) begin
            check_all("edge", sb_q.pop_front());
        end
    end

    task automatic step(input logic rst, input logic sw, input logic ff);
        logic prev_rst;
        logic prev_ff;
        prev_rst = INTERNAL_RST;
        prev_ff  = FF_US_RESTORE;
        @(negedge CLK);
        #1;
        INTERNAL_RST  = rst;
        SW_RST_REQ    = sw;
        FF_US_RESTORE = ff;
        if (!rst) active = 0;
        if (prev_rst && !rst) $display("[TB] edge %0d: INTERNAL_RST asserted", cyc);
        if ((prev_rst && !rst) || (prev_ff != ff)) begin
            #1;
            check_all("async", exp_all());
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rst) begin
            if (!active) begin
                active  = 1;
                t0      = cyc - 1;
                use_min = 0;
            end
            if (sw) begin
                t0      = cyc;
                use_min = 1;
                $display("[TB] edge %0d: SW_RST_REQ sampled", cyc);
            end
        end
        sb_q.push_back(exp_all());
    endtask

    task automatic run(input int n, input int sw_lo, input int sw_hi, input int ff_lo, input int ff_hi);
        for (int e = 1; e <= n; e++) begin
            step(1'b1, (e >= sw_lo) && (e <= sw_hi), (e >= ff_lo) && (e <= ff_hi));
        end
    endtask

    initial begin
        // Restore bypass during reset, then plain power-up with a single request at 60
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run(100, 60, 60, 30, 33);

        // Request held three edges
        step(1'b0, 1'b0, 1'b0);
        run(100, 60, 62, 0, -1);

        // Request during power-up
        step(1'b0, 1'b0, 1'b0);
        run(60, 20, 20, 0, -1);

        // Asynchronous reset mid-sequence, then a full restart
        step(1'b0, 1'b0, 1'b0);
        run(28, 0, -1, 0, -1);
        step(1'b0, 1'b0, 1'b0);
        run(50, 0, -1, 45, 47);

        for (int i = 0; i < 2000; i++) begin
            int sw_div;
            sw_div = (i < 1000) ? 30 : 120;
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, sw_div - 1) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        for (int w = 0; w < 5 && sb_q.size() != 0; w++) @(posedge CLK);
        #6;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
